// File: rtl/nibble_word_assembler.sv
// rtl/nibble_word_assembler.sv - packs 4-bit nibbles LSB-first into words with flush, parity and sequence tag
module nibble_word_assembler #(
    parameter int NIBBLES = 4,
    parameter int SEQ_W   = 8,
    parameter int W       = 4 * NIBBLES,
    parameter int CW      = $clog2(NIBBLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CW-1:0]    out_count,
    output logic             out_parity,
    output logic [SEQ_W-1:0] out_seq
);

    logic [W-1:0]     acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             flush_pending_q, flush_pending_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [CW-1:0]    out_count_q, out_count_d;
    logic             out_parity_q, out_parity_d;
    logic [SEQ_W-1:0] out_seq_q, out_seq_d;
    logic [SEQ_W-1:0] next_seq_q, next_seq_d;

    logic             slot_free;
    logic             last_slot;
    logic             accept;
    logic             word_full;
    logic             flush_req;
    logic             load;
    logic [W-1:0]     acc_merge;
    logic [CW-1:0]    cnt_after;

    assign slot_free = !out_valid_q || out_ready;
    assign last_slot = (cnt_q == CW'(NIBBLES - 1));
    assign in_ready  = !flush_pending_q && !(last_slot && !slot_free);
    assign accept    = in_valid && in_ready;
    assign word_full = accept && last_slot;
    assign cnt_after = cnt_q + CW'(accept);

    // Accumulator with this cycle's nibble already merged in; upper nibbles stay zero.
    always_comb begin
        acc_merge = acc_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (accept && (cnt_q == CW'(i))) begin
                acc_merge[4*i +: 4] = in_data;
            end
        end
    end

    // A fresh flush only matters when something is buffered and the append did not fill the word.
    assign flush_req = !word_full && (flush_pending_q || (flush && (cnt_after != '0)));
    assign load      = word_full || (flush_req && slot_free);

    always_comb begin
        acc_d           = acc_q;
        cnt_d           = cnt_q;
        flush_pending_d = flush_pending_q;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        out_count_d     = out_count_q;
        out_parity_d    = out_parity_q;
        out_seq_d       = out_seq_q;
        next_seq_d      = next_seq_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (load) begin
            out_valid_d     = 1'b1;
            out_data_d      = acc_merge;
            out_count_d     = cnt_after;
            out_parity_d    = ^acc_merge;
            out_seq_d       = next_seq_q;
            next_seq_d      = next_seq_q + SEQ_W'(1);
            acc_d           = '0;
            cnt_d           = '0;
            flush_pending_d = 1'b0;
        end else begin
            if (accept) begin
                acc_d = acc_merge;
                cnt_d = cnt_after;
            end
            if (flush_req) begin
                flush_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q           <= '0;
            cnt_q           <= '0;
            flush_pending_q <= 1'b0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_count_q     <= '0;
            out_parity_q    <= 1'b0;
            out_seq_q       <= '0;
            next_seq_q      <= '0;
        end else begin
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
            flush_pending_q <= flush_pending_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_count_q     <= out_count_d;
            out_parity_q    <= out_parity_d;
            out_seq_q       <= out_seq_d;
            next_seq_q      <= next_seq_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_count  = out_count_q;
    assign out_parity = out_parity_q;
    assign out_seq    = out_seq_q;

endmodule
